qed_dup_sequencer: RTL and testbench

- Instruction-side producer for SQED on the steelcore: sits between the constrained instruction source and the core's fetch port.
- In ORIG mode it passes instructions through using registers x0–x15 and records each one in an internal instruction cache.
- In DUP mode it replays the recorded instructions with register fields remapped to x16–x31, then drains the pipeline.
- It then raises sif_commit / qed_check_valid, the point at which the formal harness checks reg[j]==reg[j+16].

---
 rtl/qed_pkg.sv | 47 ++++
 rtl/qed_icache.sv | 59 +++++
 rtl/qed_dup_sequencer.sv | 143 ++++++++++++++
 tb/tb_qed_dup_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/qed_pkg.sv
// Shared types, opcode constants and the register-field remapping used by the SQED sequencer.
package qed_pkg;

    typedef enum logic [1:0] {
        ORIG   = 2'd0,
        DUP    = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } sif_state_e;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_IALU   = 7'b0010011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // x0 must stay x0 in the duplicate half so hard-wired zero semantics match.
    function automatic logic [4:0] map_field(input logic [4:0] f, input logic dup);
        logic [4:0] r;
        if (dup)
            r = (f == 5'd0) ? f : (f | 5'h10);
        else
            r = f & 5'h0f;
        return r;
    endfunction

    function automatic logic [31:0] map_regs(input logic [31:0] instr, input logic dup);
        logic [31:0] r;
        r = instr;
        case (instr[6:0])
            OP_R: begin
                r[11:7]  = map_field(instr[11:7], dup);
                r[19:15] = map_field(instr[19:15], dup);
                r[24:20] = map_field(instr[24:20], dup);
            end
            OP_IALU: begin
                r[11:7]  = map_field(instr[11:7], dup);
                r[19:15] = map_field(instr[19:15], dup);
            end
            OP_LUI: begin
                r[11:7]  = map_field(instr[11:7], dup);
            end
            default: r = NOP_INSTR;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/qed_icache.sv
// Instruction cache for the SQED sequencer: originals are pushed at the tail, replayed from the head.
module qed_icache #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    input  logic        clear,
    output logic [31:0] head_data,
    output logic        full,
    output logic        empty
);

    logic [31:0]   i_cache [DEPTH];
    logic [AW-1:0] address_head;
    logic [AW-1:0] address_tail;
    logic [CW-1:0] count_reg;

    // Contents are reset so the formal harness starts from a known cache image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                i_cache[i] <= '0;
        end else if (push) begin
            i_cache[address_tail] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address_head <= '0;
            address_tail <= '0;
            count_reg    <= '0;
        end else if (clear) begin
            address_head <= '0;
            address_tail <= '0;
            count_reg    <= '0;
        end else begin
            if (push)
                address_tail <= address_tail + AW'(1);
            if (pop)
                address_head <= address_head + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = i_cache[address_head];
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);

endmodule

// File: rtl/qed_dup_sequencer.sv
// SQED instruction sequencer: ORIG pass-through, DUP replay on x16-x31, DRAIN, one-cycle COMMIT.
// Optional macro QED_EXE_DUP_EN adds the exe_dup port so the epoch length becomes symbolic.
module qed_dup_sequencer
    import qed_pkg::*;
#(
    parameter  int DEPTH        = 16,
    parameter  int DRAIN_CYCLES = 5,
    localparam int CW           = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   ifu_instr,
    input  logic          ifu_valid,
    output logic          ifu_ready,
    input  logic          pipe_ready,
    output logic [31:0]   qed_instr,
    output logic          qed_valid,
    output logic [CW-1:0] qed_num_orig,
    output logic [CW-1:0] qed_num_dup,
    output logic [1:0]    sif_state,
    output logic          sif_commit,
`ifdef QED_EXE_DUP_EN
    output logic          qed_check_valid,
    input  logic          exe_dup
`else
    output logic          qed_check_valid
`endif
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    sif_state_e    state_reg;
    logic [CW-1:0] num_orig_reg;
    logic [CW-1:0] num_dup_reg;
    logic [DW-1:0] drain_reg;

    logic          dup_trigger;
    logic          orig_fire;
    logic          dup_fire;
    logic          cache_full;
    logic          cache_empty;
    logic [31:0]   cache_head;

`ifdef QED_EXE_DUP_EN
    assign dup_trigger = cache_full || (exe_dup && (num_orig_reg != '0));
`else
    assign dup_trigger = cache_full;
`endif

    assign orig_fire = (state_reg == ORIG) && !dup_trigger && ifu_valid && pipe_ready;
    assign dup_fire  = (state_reg == DUP) && pipe_ready && !cache_empty;

    qed_icache #(.DEPTH(DEPTH)) qic (
        .clk       (clk),
        .rst       (rst),
        .push      (orig_fire),
        .push_data (map_regs(ifu_instr, 1'b0)),
        .pop       (dup_fire),
        .clear     (state_reg == COMMIT),
        .head_data (cache_head),
        .full      (cache_full),
        .empty     (cache_empty)
    );

    // COMMIT and the ORIG->DUP switch offer nothing to the core, so they do not wait on pipe_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ORIG;
            num_orig_reg <= '0;
            num_dup_reg  <= '0;
            drain_reg    <= '0;
        end else begin
            case (state_reg)
                ORIG: begin
                    if (dup_trigger)
                        state_reg <= DUP;
                    else if (orig_fire)
                        num_orig_reg <= num_orig_reg + CW'(1);
                end
                DUP: begin
                    if (dup_fire) begin
                        num_dup_reg <= num_dup_reg + CW'(1);
                        if (num_dup_reg + CW'(1) == num_orig_reg) begin
                            state_reg <= DRAIN;
                            drain_reg <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_ready) begin
                        if (drain_reg == DW'(DRAIN_CYCLES - 1))
                            state_reg <= COMMIT;
                        else
                            drain_reg <= drain_reg + DW'(1);
                    end
                end
                COMMIT: begin
                    state_reg    <= ORIG;
                    num_orig_reg <= '0;
                    num_dup_reg  <= '0;
                    drain_reg    <= '0;
                end
                default: state_reg <= ORIG;
            endcase
        end
    end

    always_comb begin
        ifu_ready       = 1'b0;
        qed_valid       = 1'b0;
        qed_instr       = NOP_INSTR;
        sif_commit      = 1'b0;
        qed_check_valid = 1'b0;
        if (!rst) begin
            case (state_reg)
                ORIG: begin
                    if (!dup_trigger) begin
                        ifu_ready = pipe_ready;
                        qed_valid = ifu_valid;
                        qed_instr = map_regs(ifu_instr, 1'b0);
                    end
                end
                DUP: begin
                    qed_valid = !cache_empty;
                    qed_instr = map_regs(cache_head, 1'b1);
                end
                DRAIN: begin
                    qed_valid = 1'b1;
                end
                COMMIT: begin
                    sif_commit      = 1'b1;
                    qed_check_valid = (num_orig_reg == num_dup_reg) && (num_orig_reg != '0);
                end
                default: ;
            endcase
        end
    end

    assign qed_num_orig = num_orig_reg;
    assign qed_num_dup  = num_dup_reg;
    assign sif_state    = state_reg;

endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Directed bench for qed_dup_sequencer: full epoch with remap scoreboard, stalls, async reset.
module tb_qed_dup_sequencer;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   ifu_instr;
    logic          ifu_valid;
    logic          ifu_ready;
    logic          pipe_ready;
    logic [31:0]   qed_instr;
    logic          qed_valid;
    logic [CW-1:0] qed_num_orig;
    logic [CW-1:0] qed_num_dup;
    logic [1:0]    sif_state;
    logic          sif_commit;
    logic          qed_check_valid;
`ifdef QED_EXE_DUP_EN
    logic          exe_dup = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tab [16] = '{
        32'h002081B3, 32'h00500013, 32'h01F08093, 32'h0000A103,
        32'h123452B7, 32'h014A0A33, 32'h41DF0FB3, 32'hFFF8F813,
        32'h0000006F, 32'h0FF54493, 32'hABCDE037, 32'h01F19113,
        32'h00112023, 32'h00000033, 32'h01F867B3, 32'h41F2D293
    };

    qed_dup_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .ifu_instr       (ifu_instr),
        .ifu_valid       (ifu_valid),
        .ifu_ready       (ifu_ready),
        .pipe_ready      (pipe_ready),
        .qed_instr       (qed_instr),
        .qed_valid       (qed_valid),
        .qed_num_orig    (qed_num_orig),
        .qed_num_dup     (qed_num_dup),
        .sif_state       (sif_state),
        .sif_commit      (sif_commit),
`ifdef QED_EXE_DUP_EN
        .qed_check_valid (qed_check_valid),
        .exe_dup         (exe_dup)
`else
        .qed_check_valid (qed_check_valid)
`endif
    );

    always #5 clk = ~clk;

    // Reference remap: pick which fields exist per opcode, then rewrite each one.
    function automatic logic [31:0] ref_map(input logic [31:0] i, input logic dup);
        logic [31:0] r;
        logic [4:0]  f;
        bit has_rd, has_rs1, has_rs2;
        has_rd  = (i[6:0] == 7'h33) || (i[6:0] == 7'h13) || (i[6:0] == 7'h37);
        has_rs1 = (i[6:0] == 7'h33) || (i[6:0] == 7'h13);
        has_rs2 = (i[6:0] == 7'h33);
        if (!has_rd) return NOP;
        r = i;
        for (int k = 0; k < 3; k++) begin
            if ((k == 0 && has_rd) || (k == 1 && has_rs1) || (k == 2 && has_rs2)) begin
                f = (k == 0) ? i[11:7] : (k == 1) ? i[19:15] : i[24:20];
                if (dup) f = (f != 5'd0) ? {1'b1, f[3:0]} : 5'd0;
                else     f = {1'b0, f[3:0]};
                case (k)
                    0:       r[11:7]  = f;
                    1:       r[19:15] = f;
                    default: r[24:20] = f;
                endcase
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] o;
        rst        = 1'b1;
        ifu_instr  = tab[0];
        ifu_valid  = 1'b1;
        pipe_ready = 1'b1;
        #2;
        check("rst_qed_valid", 32'(qed_valid), 32'd0);
        check("rst_ifu_ready", 32'(ifu_ready), 32'd0);
        check("rst_qed_instr", qed_instr, NOP);
        check("rst_sif_commit", 32'(sif_commit), 32'd0);
        check("rst_state", 32'(sif_state), 32'd0);
        check("rst_num_orig", 32'(qed_num_orig), 32'd0);
        tick();
        rst = 1'b0;

        // Epoch 1: sixteen originals, one ORIG stall before entry 7
        for (int i = 0; i < DEPTH; i++) begin
            ifu_valid = 1'b1;
            ifu_instr = tab[i];
            if (i == 7) begin
                pipe_ready = 1'b0;
                @(negedge clk);
                check("orig_stall_ready", 32'(ifu_ready), 32'd0);
                tick();
                check("orig_stall_count", 32'(qed_num_orig), 32'd7);
            end
            pipe_ready = 1'b1;
            @(negedge clk);
            check("orig_state", 32'(sif_state), 32'd0);
            check("orig_ready", 32'(ifu_ready), 32'd1);
            check("orig_valid", 32'(qed_valid), 32'd1);
            check("orig_instr", qed_instr, ref_map(tab[i], 1'b0));
            case (i)
                0: check("orig_add_lit", qed_instr, 32'h002081B3);
                3: check("orig_load_nop", qed_instr, NOP);
                5: check("orig_x20_lit", qed_instr, 32'h00420233);
                default: ;
            endcase
            exp_q.push_back(ref_map(ref_map(tab[i], 1'b0), 1'b1));
            tick();
            check("orig_count", 32'(qed_num_orig), i + 1);
            if (i == 0) check("cache0", dut.qic.i_cache[0], 32'h002081B3);
        end

        @(negedge clk);
        check("full_ifu_ready", 32'(ifu_ready), 32'd0);
        check("full_qed_valid", 32'(qed_valid), 32'd0);
        tick();
        ifu_valid = 1'b0;

        // Duplicates with a three-cycle stall before entry 5
        for (int j = 0; j < DEPTH; j++) begin
            if (j == 5) begin
                pipe_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check("stall_instr", qed_instr, exp_q[0]);
                    tick();
                    check("stall_num_dup", 32'(qed_num_dup), 32'd5);
                end
                pipe_ready = 1'b1;
            end
            @(negedge clk);
            check("dup_state", 32'(sif_state), 32'd1);
            check("dup_valid", 32'(qed_valid), 32'd1);
            o = exp_q.pop_front();
            check("dup_instr", qed_instr, o);
            case (j)
                0: check("dup_add_lit", qed_instr, 32'h012889B3);
                1: check("dup_x0_imm_lit", qed_instr, 32'h00500013);
                2: check("dup_addi_lit", qed_instr, 32'h01F88893);
                4: check("dup_lui_lit", qed_instr, 32'h12345AB7);
                5: check("dup_x20_lit", qed_instr, 32'h014A0A33);
                default: ;
            endcase
            tick();
            check("dup_count", 32'(qed_num_dup), j + 1);
        end
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        // Drain: six cycles with one stall give five accepted NOPs
        for (int d = 0; d < 6; d++) begin
            pipe_ready = (d != 2);
            @(negedge clk);
            check("drain_state", 32'(sif_state), 32'd2);
            check("drain_instr", qed_instr, NOP);
            tick();
        end
        pipe_ready = 1'b1;
        @(negedge clk);
        check("commit_state", 32'(sif_state), 32'd3);
        check("commit_pulse", 32'(sif_commit), 32'd1);
        check("commit_check_valid", 32'(qed_check_valid), 32'd1);
        check("commit_qed_valid", 32'(qed_valid), 32'd0);
        tick();
        @(negedge clk);
        check("post_state", 32'(sif_state), 32'd0);
        check("post_commit", 32'(sif_commit), 32'd0);
        check("post_num_orig", 32'(qed_num_orig), 32'd0);
        check("post_num_dup", 32'(qed_num_dup), 32'd0);

        // Epoch 2: async reset after two duplicates
        tick();
        ifu_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ifu_instr = tab[i];
            tick();
        end
        ifu_valid = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_num_dup", 32'(qed_num_dup), 32'd2);
        check("pre_rst_state", 32'(sif_state), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_num_orig", 32'(qed_num_orig), 32'd0);
        check("arst_num_dup", 32'(qed_num_dup), 32'd0);
        check("arst_state", 32'(sif_state), 32'd0);
        check("arst_qed_valid", 32'(qed_valid), 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("no_commit_after_rst", 32'(sif_commit), 32'd0);
            tick();
        end
        check("idle_state", 32'(sif_state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
